// File: rtl/pe_ws_ctrl.sv
// Weight-stationary sequencer for one PE: loads a weight stream into the PE
// scratchpad, then replays each weight for a programmed number of activations.
module pe_ws_ctrl #(
   parameter int MEM_ADDR_BITWIDTH = 10,
   parameter int WGT_BITWIDTH      = 8,
   parameter int CNT_BITWIDTH      = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [MEM_ADDR_BITWIDTH-1:0] num_wgt_m1,
   input  logic [CNT_BITWIDTH-1:0]      num_act_m1,
   input  logic                         wgt_valid,
   input  logic [WGT_BITWIDTH-1:0]      wgt_data,
   output logic                         wgt_ready,
   input  logic                         act_valid,
   output logic                         act_ready,
   output logic                         write_req_w_mem,
   output logic [MEM_ADDR_BITWIDTH-1:0] w_addr_w_mem,
   output logic [WGT_BITWIDTH-1:0]      w_data_w_mem,
   output logic                         read_req_w_mem,
   output logic [MEM_ADDR_BITWIDTH-1:0] r_addr_w_mem,
   output logic                         ws_en,
   output logic                         ws_mux,
   output logic                         reset_ws_reg,
   output logic                         reset_reg,
   output logic                         wrt_en_reg,
   output logic                         busy,
   output logic                         done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_FETCH,
      S_CAPTURE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic [MEM_ADDR_BITWIDTH-1:0] n_m1;
   logic [CNT_BITWIDTH-1:0]      m_m1;
   logic [MEM_ADDR_BITWIDTH-1:0] wr_cnt;
   logic [MEM_ADDR_BITWIDTH-1:0] wgt_idx;
   logic [CNT_BITWIDTH-1:0]      act_cnt;
   logic                         write_req_q;
   logic [MEM_ADDR_BITWIDTH-1:0] w_addr_q;
   logic [WGT_BITWIDTH-1:0]      w_data_q;
   logic                         clr_q;

   logic act_last;

   // The M-th consumed activation of the current weight (CAPTURE counts too).
   assign act_last = act_valid && (act_cnt == m_m1);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next     = state;
      wgt_ready      = 1'b0;
      act_ready      = 1'b0;
      read_req_w_mem = 1'b0;
      ws_en          = 1'b0;
      ws_mux         = 1'b0;
      busy           = 1'b1;
      done           = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_next = S_LOAD;
         end
         S_LOAD: begin
            wgt_ready = 1'b1;
            if (wgt_valid && (wr_cnt == n_m1)) state_next = S_WAIT;
         end
         S_WAIT:  state_next = S_FETCH;
         S_FETCH: begin
            read_req_w_mem = 1'b1;
            state_next     = S_CAPTURE;
         end
         S_CAPTURE, S_STREAM: begin
            act_ready = 1'b1;
            if (state == S_CAPTURE) begin
               ws_en  = 1'b1;
               ws_mux = 1'b1;
            end
            if (act_last)                  state_next = (wgt_idx == n_m1) ? S_DONE : S_FETCH;
            else if (state == S_CAPTURE)   state_next = S_STREAM;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign wrt_en_reg = act_valid & act_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         n_m1        <= '0;
         m_m1        <= '0;
         wr_cnt      <= '0;
         wgt_idx     <= '0;
         act_cnt     <= '0;
         write_req_q <= 1'b0;
         w_addr_q    <= '0;
         w_data_q    <= '0;
         clr_q       <= 1'b0;
      end else begin
         write_req_q <= 1'b0;
         clr_q       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_m1    <= num_wgt_m1;
                  m_m1    <= num_act_m1;
                  wr_cnt  <= '0;
                  wgt_idx <= '0;
                  act_cnt <= '0;
                  clr_q   <= 1'b1;
               end
            end
            S_LOAD: begin
               if (wgt_valid) begin
                  write_req_q <= 1'b1;
                  w_addr_q    <= wr_cnt;
                  w_data_q    <= wgt_data;
                  wr_cnt      <= wr_cnt + 1'b1;
               end
            end
            S_CAPTURE, S_STREAM: begin
               if (act_last) begin
                  act_cnt <= '0;
                  if (wgt_idx != n_m1) wgt_idx <= wgt_idx + 1'b1;
               end else if (act_valid) begin
                  act_cnt <= act_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign write_req_w_mem = write_req_q;
   assign w_addr_w_mem    = w_addr_q;
   assign w_data_w_mem    = w_data_q;
   assign r_addr_w_mem    = wgt_idx;
   assign reset_reg       = clr_q;
   assign reset_ws_reg    = clr_q;

endmodule
